pip_issue_unit: RTL and testbench

PIP_ISSUE_UNIT -- requirements
Module: pip_issue_unit

---
 rtl/pip_issue_unit.sv | 100 ++++++++++
 tb/tb_pip_issue_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pip_issue_unit.sv
// rtl/pip_issue_unit.sv - 4-entry instruction/operand FIFO feeding a 4-stage ADD/SUB processor
module pip_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_instr,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       issue_en,
  output logic [7:0] instr_out,
  output logic [7:0] data_a_out,
  output logic [7:0] data_b_out,
  output logic       res_valid,
  output logic [2:0] fifo_count,
  output logic [7:0] issued_count,
  output logic       illegal_seen
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [2:0] FULL   = 3'(DEPTH);

  logic [7:0] mem_instr [4];
  logic [7:0] mem_a     [4];
  logic [7:0] mem_b     [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [7:0] pend_a;
  logic [7:0] pend_b;
  logic [3:0] res_sr;

  logic       push;
  logic       pop;
  logic [7:0] head_instr;
  logic       head_legal;
  logic       head_arith;
  logic       out_arith;

  assign in_ready   = (fifo_count < FULL) && !reset;
  assign push       = in_valid && in_ready;
  assign pop        = issue_en && (fifo_count != 3'd0);
  assign head_instr = mem_instr[rd_ptr];
  assign head_arith = (head_instr == OP_ADD) || (head_instr == OP_SUB);
  assign head_legal = head_arith || (head_instr == OP_NOP);
  assign out_arith  = (instr_out == OP_ADD) || (instr_out == OP_SUB);
  // res_sr[0] follows the cycle after an ADD/SUB sits on instr_out, so bit 3 lands at N+4
  assign res_valid  = res_sr[3];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_a[wr_ptr]     <= in_a;
      mem_b[wr_ptr]     <= in_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      fifo_count   <= 3'd0;
      instr_out    <= OP_NOP;
      pend_a       <= 8'h00;
      pend_b       <= 8'h00;
      data_a_out   <= 8'h00;
      data_b_out   <= 8'h00;
      res_sr       <= 4'b0000;
      issued_count <= 8'h00;
      illegal_seen <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
      // Operands trail the opcode by one stage; bubbles and illegal slots carry zeros
      if (pop && head_legal) begin
        instr_out <= head_instr;
        pend_a    <= mem_a[rd_ptr];
        pend_b    <= mem_b[rd_ptr];
      end else begin
        instr_out <= OP_NOP;
        pend_a    <= 8'h00;
        pend_b    <= 8'h00;
      end
      data_a_out <= pend_a;
      data_b_out <= pend_b;
      res_sr     <= {res_sr[2:0], out_arith};
      if (pop && head_arith) issued_count <= issued_count + 8'd1;
      if (pop && !head_legal) illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pip_issue_unit.sv
// tb/tb_pip_issue_unit.sv - directed vector bench for pip_issue_unit
module tb_pip_issue_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_instr = 8'h00;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       issue_en = 1'b0;
  logic [7:0] instr_out;
  logic [7:0] data_a_out;
  logic [7:0] data_b_out;
  logic       res_valid;
  logic [2:0] fifo_count;
  logic [7:0] issued_count;
  logic       illegal_seen;

  int total = 0;
  int bad = 0;

  pip_issue_unit #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_a(in_a), .in_b(in_b), .issue_en(issue_en),
    .instr_out(instr_out), .data_a_out(data_a_out), .data_b_out(data_b_out),
    .res_valid(res_valid), .fifo_count(fifo_count), .issued_count(issued_count),
    .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  // Processor model: opcode in cycle N, operands in N+1, result visible in N+4
  logic [7:0] pm_op = 8'h00, p1 = 8'h00, p2 = 8'h00, p3 = 8'h00;
  always @(posedge clk) begin
    pm_op <= instr_out;
    case (pm_op)
      8'h01:   p1 <= data_a_out + data_b_out;
      8'h02:   p1 <= data_a_out - data_b_out;
      default: p1 <= 8'h00;
    endcase
    p2 <= p1;
    p3 <= p2;
  end

  typedef struct {
    logic       iv;
    logic [7:0] ins, a, b;
    logic       ie;
    logic       e_ir;
    logic [7:0] e_instr, e_a, e_b;
    logic       e_rv;
    logic [7:0] e_res;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic iv, logic [7:0] ins, logic [7:0] a, logic [7:0] b, logic ie,
                             logic e_ir, logic [7:0] e_instr, logic [7:0] e_a, logic [7:0] e_b,
                             logic e_rv, logic [7:0] e_res, logic [2:0] e_cnt);
    vec_t r;
    r.iv = iv; r.ins = ins; r.a = a; r.b = b; r.ie = ie;
    r.e_ir = e_ir; r.e_instr = e_instr; r.e_a = e_a; r.e_b = e_b;
    r.e_rv = e_rv; r.e_res = e_res; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] ins, input logic [7:0] a,
                       input logic [7:0] b, input logic ie);
    in_valid = iv; in_instr = ins; in_a = a; in_b = b; issue_en = ie;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].ins, tbl[i].a, tbl[i].b, tbl[i].ie);
      @(posedge clk);
      #1;
      chk($sformatf("%s row%0d in_ready", tag, i), in_ready, tbl[i].e_ir);
      chk($sformatf("%s row%0d instr_out", tag, i), instr_out, tbl[i].e_instr);
      chk($sformatf("%s row%0d data_a_out", tag, i), data_a_out, tbl[i].e_a);
      chk($sformatf("%s row%0d data_b_out", tag, i), data_b_out, tbl[i].e_b);
      chk($sformatf("%s row%0d res_valid", tag, i), res_valid, tbl[i].e_rv);
      chk($sformatf("%s row%0d fifo_count", tag, i), fifo_count, tbl[i].e_cnt);
      if (tbl[i].e_rv) chk($sformatf("%s row%0d result", tag, i), p3, tbl[i].e_res);
    end
    tbl.delete();
  endtask

  initial begin
    int lat, run, maxrun, seen, nxt, order_bad, cnt_bad;
    logic [7:0] prev_op;

    #2;
    chk("reset instr_out", instr_out, 0);
    chk("reset data_a_out", data_a_out, 0);
    chk("reset data_b_out", data_b_out, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset issued_count", issued_count, 0);
    chk("reset illegal_seen", illegal_seen, 0);
    chk("reset in_ready", in_ready, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("in_ready after reset", in_ready, 1);

    // Single ADD (1,5,3) into empty FIFO
    tbl.push_back(v(1, 8'h01, 8'd5, 8'd3, 1,  1, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1,            1, 8'h01, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,            1, 8'h00, 5, 3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,            1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,            1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,            1, 8'h00, 0, 0, 1, 8, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,            1, 8'h00, 0, 0, 0, 0, 0));
    run_table("add");
    chk("issued after add", issued_count, 1);

    // Fill to 4 with issue halted, 5th held until the edge after the first pop
    tbl.push_back(v(1, 8'h01, 11, 1, 0,  1, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 8'h01, 12, 1, 0,  1, 8'h00, 0, 0, 0, 0, 2));
    tbl.push_back(v(1, 8'h02, 13, 1, 0,  1, 8'h00, 0, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h00, 14, 1, 0,  0, 8'h00, 0, 0, 0, 0, 4));
    tbl.push_back(v(1, 8'h01, 15, 1, 0,  0, 8'h00, 0, 0, 0, 0, 4));
    tbl.push_back(v(1, 8'h01, 15, 1, 1,  1, 8'h01, 0, 0, 0, 0, 3));
    tbl.push_back(v(1, 8'h01, 15, 1, 1,  1, 8'h01, 11, 1, 0, 0, 3));
    tbl.push_back(v(0, 0, 0, 0, 1,       1, 8'h02, 12, 1, 0, 0, 2));
    tbl.push_back(v(0, 0, 0, 0, 1,       1, 8'h00, 13, 1, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1,       1, 8'h01, 14, 1, 1, 12, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,       1, 8'h00, 15, 1, 1, 13, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,       1, 8'h00, 0, 0, 1, 12, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,       1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,       1, 8'h00, 0, 0, 1, 16, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,       1, 8'h00, 0, 0, 0, 0, 0));
    run_table("fill");
    chk("issued after fill", issued_count, 5);

    // SUB wrap: 3-5 = 0xFE, res_valid 4 cycles after it reaches instr_out
    @(negedge clk); drive(1, 8'h02, 8'd3, 8'd5, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("sub on instr_out", instr_out, 2);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (res_valid && lat < 0) begin
        lat = k;
        chk("sub result", p3, 8'hFE);
      end
    end
    chk("sub res latency", lat, 4);

    // Back-to-back ADD/SUB/ADD -> three consecutive res_valid cycles
    @(negedge clk); drive(1, 8'h01, 8'd1, 8'd2, 0);
    @(negedge clk); drive(1, 8'h02, 8'd3, 8'd5, 0);
    @(negedge clk); drive(1, 8'h01, 8'd4, 8'd4, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1);
    run = 0; maxrun = 0; seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        seen++; run++;
        if (run > maxrun) maxrun = run;
        if (seen == 2) chk("b2b sub result", p3, 8'hFE);
      end else run = 0;
    end
    chk("b2b res_valid run", maxrun, 3);
    chk("b2b res_valid total", seen, 3);
    chk("issued after b2b", issued_count, 9);

    // Illegal opcode 0x07
    @(negedge clk); drive(1, 8'h07, 8'd9, 8'd9, 1);
    @(negedge clk); drive(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("illegal instr_out", instr_out, 0);
    chk("illegal_seen set", illegal_seen, 1);
    @(posedge clk); #1;
    chk("illegal data_a_out", data_a_out, 0);
    chk("illegal data_b_out", data_b_out, 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    chk("illegal no res_valid", seen, 0);
    chk("illegal issued unchanged", issued_count, 9);
    chk("illegal_seen sticky", illegal_seen, 1);

    // Mid-operation reset: 3 entries queued, 2 ADDs in flight
    @(negedge clk); drive(1, 8'h01, 8'd1, 8'd1, 0);
    @(negedge clk); drive(1, 8'h01, 8'd2, 8'd2, 0);
    @(negedge clk); drive(1, 8'h00, 8'd0, 8'd0, 0);
    @(negedge clk); drive(1, 8'h00, 8'd0, 8'd0, 1);
    @(negedge clk); drive(1, 8'h00, 8'd0, 8'd0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre-reset fifo_count", fifo_count, 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async reset fifo_count", fifo_count, 0);
    chk("async reset res_valid", res_valid, 0);
    chk("async reset in_ready", in_ready, 0);
    chk("async reset illegal_seen", illegal_seen, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 1);
    #1 chk("in_ready after mid reset", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (res_valid || instr_out != 8'h00) seen++;
    end
    chk("no activity after reset", seen, 0);

    // 260 ADDs streamed with continuous push/pop
    nxt = 0; order_bad = 0; cnt_bad = 0; prev_op = 8'h00;
    for (int k = 0; k < 266; k++) begin
      @(negedge clk);
      if (k < 260) drive(1, 8'h01, k[7:0], 8'h00, 1);
      else drive(0, 0, 0, 0, 1);
      @(posedge clk); #1;
      if (fifo_count > 3'd1) cnt_bad++;
      if (prev_op == 8'h01) begin
        if (data_a_out !== nxt[7:0]) order_bad++;
        nxt++;
      end
      prev_op = instr_out;
    end
    chk("wrap order errors", order_bad, 0);
    chk("wrap fifo_count over 1", cnt_bad, 0);
    chk("wrap issues seen", nxt, 260);
    chk("wrap issued_count", issued_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
